// File: rtl/sw_pkg.sv
// Shared types and helpers for the switch arbiter.
package sw_pkg;

  localparam int NPORT = 4;

  typedef logic [1:0] port_id_t;

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_t;

  // Port-ID constants also used by sw.vh consumers
  localparam port_id_t PORT0 = 2'd0;
  localparam port_id_t PORT1 = 2'd1;
  localparam port_id_t PORT2 = 2'd2;
  localparam port_id_t PORT3 = 2'd3;

  // Index -> one-hot port vector
  function automatic logic [NPORT-1:0] id2onehot(input port_id_t id);
    logic [NPORT-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // One-hot port vector -> index (lowest set bit wins if not one-hot)
  function automatic port_id_t onehot2id(input logic [NPORT-1:0] v);
    port_id_t id;
    id = PORT0;
    for (int i = NPORT - 1; i >= 0; i--) begin
      if (v[i]) id = port_id_t'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/sw_arbiter_rr_pick.sv
// Rotating-priority encoder: first requester at or after ptr, wrapping.
module rr_pick
  import sw_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  port_id_t         ptr,
  output logic             valid,
  output port_id_t         id
);

  // Walk offsets from highest to lowest so the smallest offset from ptr wins
  always_comb begin
    port_id_t idx;
    valid = 1'b0;
    id    = ptr;
    idx   = ptr;
    for (int k = NPORT - 1; k >= 0; k--) begin
      idx = ptr + port_id_t'(k);
      if (req[idx]) begin
        valid = 1'b1;
        id    = idx;
      end
    end
  end

endmodule

// File: rtl/sw_arbiter.sv
// Round-robin arbiter for the shared switch resource with a grant watchdog.
module sw_arbiter
  import sw_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NPORT-1:0] req,
  input  logic             ack,
  output logic [NPORT-1:0] gnt,
  output logic [1:0]       gnt_id,
  output logic             busy,
  output logic             err
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  localparam logic [7:0] HOLD_SAT  = 8'(HOLD_MAX);

  arb_state_t       state_q, state_d;
  logic [NPORT-1:0] gnt_q, gnt_d;
  port_id_t         gnt_id_q, gnt_id_d;
  port_id_t         ptr_q, ptr_d;
  logic [7:0]       hold_q, hold_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic             pick_valid;
  port_id_t         pick_id;

  // Single picker shared by IDLE and RELEASE; both arbitrate from ptr_q
  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .id    (pick_id)
  );

  // Next-state and registered-output computation
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE, RELEASE: begin
        if (pick_valid) begin
          gnt_d    = id2onehot(pick_id);
          gnt_id_d = pick_id;
          hold_d   = '0;
          state_d  = GRANT;
        end else begin
          state_d  = IDLE;
        end
      end
      GRANT: begin
        hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + 8'd1;
        // ack outranks abort, abort outranks the watchdog
        if (ack || !req[gnt_id_q] || hold_q == HOLD_LAST) begin
          err_d   = !ack && req[gnt_id_q];
          gnt_d   = '0;
          ptr_d   = gnt_id_q + port_id_t'(1);
          state_d = RELEASE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = |gnt_d;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= PORT0;
      ptr_q    <= PORT0;
      hold_q   <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;
  assign err    = err_q;

endmodule
